// File: rtl/exc_unit_pkg.sv
// Shared definitions for the exception/interrupt responder: cause codes,
// FSM state encoding, the save-stack entry layout and the vector helper.
package exc_unit_pkg;

  localparam logic [4:0] CAUSE_ECALL    = 5'd8;
  localparam logic [4:0] CAUSE_IRQ0     = 5'd16;
  localparam int         NEST_DEPTH_MAX = 4;

  typedef enum logic [1:0] {
    EXC_RUN   = 2'd0,
    EXC_REDIR = 2'd1,
    EXC_DRAIN = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        ie;
  } exc_entry_t;

  // Handler address for a cause; wraps modulo 2^32.
  function automatic logic [31:0] trap_vector(logic [31:0] base, logic [4:0] cause);
    return base + {25'd0, cause, 2'b00};
  endfunction

endpackage

// File: rtl/exc_unit_if.sv
// Pipeline <-> exception unit signal bundle. The pipeline side is the
// master; the exception unit is the slave.
interface exc_unit_if #(
  parameter int IRQ_NUM = 4
);
  logic               mem_valid;
  logic               mem_stall;
  logic [31:0]        mem_pc;
  logic               mem_ecall;
  logic               mem_eret;
  logic               mem_eretn;
  logic [IRQ_NUM-1:0] irq;
  logic               mask_we;
  logic [IRQ_NUM-1:0] mask_wdata;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        epc;
  logic [4:0]         cause;
  logic               ie;
  logic [2:0]         depth;
  logic               err;

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_ecall, mem_eret, mem_eretn,
           irq, mask_we, mask_wdata,
    input  flush, redirect, redirect_pc, epc, cause, ie, depth, err
  );

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_ecall, mem_eret, mem_eretn,
           irq, mask_we, mask_wdata,
    output flush, redirect, redirect_pc, epc, cause, ie, depth, err
  );
endinterface

// File: rtl/exc_unit_stack.sv
// LIFO of {epc, cause, ie} used to save trap context for nested traps.
// The top entry reads as all zeros while the stack is empty.
module exc_stack
  import exc_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  exc_entry_t push_entry,
  output exc_entry_t top,
  output logic [2:0] depth,
  output logic       full,
  output logic       empty
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  exc_entry_t       mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (depth == 3'(DEPTH));
  assign empty  = (depth == 3'd0);
  assign wr_idx = IDX_W'(depth);
  assign rd_idx = IDX_W'(depth - 3'd1);
  assign top    = empty ? '0 : mem[rd_idx];

  // Occupancy counter; push and pop are never requested together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      depth <= 3'd0;
    end else if (push && !full) begin
      depth <= depth + 3'd1;
    end else if (pop && !empty) begin
      depth <= depth - 3'd1;
    end
  end

  // Entry storage; writes land at the current depth.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; depth==0 already masks
    // stale entries, and a reset-free array maps onto plain RAM/flops.
    if (!rst && push && !full) begin
      mem[wr_idx] <= push_entry;
    end
  end

endmodule

// File: rtl/exc_unit.sv
// Exception/interrupt responder: picks the highest-priority MEM-stage event,
// saves/restores trap context on the nest stack and issues a one-cycle
// flush + PC redirect, then drains squashed instructions for one cycle.
module exc_unit
  import exc_unit_pkg::*;
#(
  parameter int          IRQ_NUM    = 4,
  parameter int          NEST_DEPTH = 2,   // 1..NEST_DEPTH_MAX
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100
) (
  input logic       clk,
  input logic       rst,
  exc_unit_if.slave bus
);
  exc_state_e         state;
  logic               flush_q;
  logic               redirect_q;
  logic               ie_q;
  logic               err_q;
  logic [31:0]        redirect_pc_q;
  logic [IRQ_NUM-1:0] irq_q;
  logic [IRQ_NUM-1:0] mask_q;
  logic [IRQ_NUM-1:0] pending;

  exc_entry_t  push_entry;
  exc_entry_t  top;
  logic [2:0]  depth;
  logic        full;
  logic        empty;
  logic        accept;
  logic        do_push;
  logic        do_pop;
  logic        err_set;
  logic        ie_next;
  logic        irq_hit;
  logic [4:0]  irq_idx;
  logic [31:0] target;

  assign accept  = bus.mem_valid & ~bus.mem_stall & (state == EXC_RUN);
  assign pending = irq_q & mask_q;

  // Lowest-numbered pending interrupt line wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    irq_hit = 1'b0;
    irq_idx = 5'd0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (pending[k]) begin
        irq_hit = 1'b1;
        irq_idx = 5'(k);
      end
    end
  end

  // Event priority ecall > eret > eretn > irq, and the resulting redirect.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    err_set    = 1'b0;
    ie_next    = ie_q;
    target     = redirect_pc_q;
    push_entry = '{epc: bus.mem_pc, cause: CAUSE_IRQ0 + irq_idx, ie: ie_q};
    if (accept) begin
      if (bus.mem_ecall) begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          do_push          = 1'b1;
          push_entry.epc   = bus.mem_pc + 32'd4;
          push_entry.cause = CAUSE_ECALL;
          ie_next          = 1'b0;
        end
      end else if (bus.mem_eret || bus.mem_eretn) begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          do_pop  = 1'b1;
          ie_next = bus.mem_eretn ? 1'b1 : top.ie;
          target  = top.epc;
        end
      end else if (irq_hit && ie_q && !full) begin
        // Interrupted instruction re-executes, so epc is its own PC.
        do_push = 1'b1;
        ie_next = 1'b0;
      end
    end
    if (do_push) begin
      target = trap_vector(VEC_BASE, push_entry.cause);
    end
  end

  exc_stack #(.DEPTH(NEST_DEPTH)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (do_push),
    .pop        (do_pop),
    .push_entry (push_entry),
    .top        (top),
    .depth      (depth),
    .full       (full),
    .empty      (empty)
  );

  // Control FSM plus registered redirect, ie, sticky err and irq sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EXC_RUN;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      ie_q          <= 1'b1;
      err_q         <= 1'b0;
      irq_q         <= '0;
      mask_q        <= '1;
    end else begin
      irq_q      <= bus.irq;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      if (err_set)     err_q  <= 1'b1;
      case (state)
        EXC_RUN: begin
          if (do_push || do_pop) begin
            state         <= EXC_REDIR;
            flush_q       <= 1'b1;
            redirect_q    <= 1'b1;
            redirect_pc_q <= target;
            ie_q          <= ie_next;
          end
        end
        EXC_REDIR: state <= EXC_DRAIN;
        EXC_DRAIN: state <= EXC_RUN;
        default:   state <= EXC_RUN;
      endcase
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.epc         = top.epc;
  assign bus.cause       = top.cause;
  assign bus.ie          = ie_q;
  assign bus.depth       = depth;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_exc_unit.sv
// Bench for exc_unit: a directed opening sequence followed by random
// stimulus, every cycle compared against a queue-based reference model.
module tb_exc_unit;
  localparam int          IRQ_NUM = 4;
  localparam int          NEST    = 2;
  localparam logic [31:0] VEC     = 32'h0000_0100;

  typedef struct {
    logic [31:0] epc;
    logic [4:0]  cause;
    bit          ie;
  } ment_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exc_unit_if #(.IRQ_NUM(IRQ_NUM)) bus ();

  exc_unit #(.IRQ_NUM(IRQ_NUM), .NEST_DEPTH(NEST), .VEC_BASE(VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  ment_t       q[$];
  bit          m_ie    = 1'b1;
  bit          m_err   = 1'b0;
  bit          m_flush = 1'b0;
  logic [31:0] m_rpc   = 32'd0;
  logic [3:0]  m_irq_q = 4'd0;
  logic [3:0]  m_mask  = 4'hF;
  int          busy    = 0;   // cycles left during which events are ignored

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [3:0] pend;
    int         idx;
    bit         acc;
    bit         trap;
    ment_t      e;
    if (rst) begin
      q.delete();
      m_ie = 1'b1; m_err = 1'b0; m_flush = 1'b0; m_rpc = 32'd0;
      m_irq_q = 4'd0; m_mask = 4'hF; busy = 0;
      return;
    end
    pend = m_irq_q & m_mask;
    acc  = bus.mem_valid && !bus.mem_stall && (busy == 0);
    trap = 1'b0;
    if (busy > 0) busy--;
    if (acc) begin
      if (bus.mem_ecall) begin
        if (q.size() < NEST) begin
          q.push_back('{bus.mem_pc + 32'd4, 5'd8, m_ie});
          m_rpc = VEC + 32'd8 * 32'd4;
          m_ie  = 1'b0;
          trap  = 1'b1;
        end else m_err = 1'b1;
      end else if (bus.mem_eret || bus.mem_eretn) begin
        if (q.size() > 0) begin
          e     = q.pop_back();
          m_rpc = e.epc;
          m_ie  = bus.mem_eretn ? 1'b1 : e.ie;
          trap  = 1'b1;
        end else m_err = 1'b1;
      end else begin
        idx = -1;
        for (int k = 0; k < IRQ_NUM; k++) if (pend[k] && idx < 0) idx = k;
        if (idx >= 0 && m_ie && q.size() < NEST) begin
          q.push_back('{bus.mem_pc, 5'(16 + idx), m_ie});
          m_rpc = VEC + 32'(16 + idx) * 32'd4;
          m_ie  = 1'b0;
          trap  = 1'b1;
        end
      end
    end
    m_flush = trap;
    if (trap) busy = 2;
    m_irq_q = bus.irq;
    if (bus.mask_we) m_mask = bus.mask_wdata;
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, then compare.
  task automatic cyc(input string tag, input bit v, input bit s, input logic [31:0] pc,
                     input bit ec, input bit er, input bit ern, input logic [3:0] irq,
                     input bit mwe = 1'b0, input logic [3:0] mw = 4'h0);
    @(negedge clk);
    bus.mem_valid = v;   bus.mem_stall = s;  bus.mem_pc = pc;
    bus.mem_ecall = ec;  bus.mem_eret = er;  bus.mem_eretn = ern;
    bus.irq = irq;       bus.mask_we = mwe;  bus.mask_wdata = mw;
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".flush"},    32'(bus.flush),    32'(m_flush));
    check({tag, ".redirect"}, 32'(bus.redirect), 32'(m_flush));
    check({tag, ".rpc"},      bus.redirect_pc,   m_rpc);
    check({tag, ".epc"},      bus.epc,           (q.size() > 0) ? q[$].epc : 32'd0);
    check({tag, ".cause"},    32'(bus.cause),    (q.size() > 0) ? 32'(q[$].cause) : 32'd0);
    check({tag, ".ie"},       32'(bus.ie),       32'(m_ie));
    check({tag, ".depth"},    32'(bus.depth),    32'(q.size()));
    check({tag, ".err"},      32'(bus.err),      32'(m_err));
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_stall = 1'b0; bus.mem_pc = 32'd0;
    bus.mem_ecall = 1'b0; bus.mem_eret = 1'b0;  bus.mem_eretn = 1'b0;
    bus.irq = '0;         bus.mask_we = 1'b0;   bus.mask_wdata = '0;

    // Reset state.
    rst = 1'b1;
    cyc("reset", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("reset", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    check("reset_ie", 32'(bus.ie), 32'd1);
    rst = 1'b0;

    // ecall at 0x40 from an empty stack.
    cyc("ecall", 1, 0, 32'h40, 1, 0, 0, 4'h0);
    check("ecall_vec", bus.redirect_pc, 32'h120);
    check("ecall_epc", bus.epc, 32'h44);
    // Events in REDIR/DRAIN are dropped.
    cyc("redir_drop", 1, 0, 32'h50, 1, 0, 0, 4'h0);
    cyc("drain_drop", 1, 0, 32'h54, 0, 1, 0, 4'h0);
    check("drain_noflush", 32'(bus.flush), 32'd0);

    // Stalled eret is not accepted, then the real return.
    cyc("stall", 1, 1, 32'h58, 0, 1, 0, 4'h0);
    cyc("eret", 1, 0, 32'h200, 0, 1, 0, 4'h0);
    check("eret_rpc", bus.redirect_pc, 32'h44);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);

    // Return with an empty stack sets the sticky error.
    cyc("eret_empty", 1, 0, 32'h60, 0, 1, 0, 4'h0);
    check("eret_empty_err", 32'(bus.err), 32'd1);

    // irq[2] then irq[0]&irq[2] together after the first returns.
    cyc("irq_arm", 0, 0, 32'd0, 0, 0, 0, 4'b0100);
    cyc("irq2", 1, 0, 32'h80, 0, 0, 0, 4'b0100);
    check("irq2_vec", bus.redirect_pc, 32'h148);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("eretn", 1, 0, 32'h14C, 0, 0, 1, 4'b0101);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'b0101);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'b0101);
    cyc("irq02", 1, 0, 32'h90, 0, 0, 0, 4'b0101);
    check("irq02_cause", 32'(bus.cause), 32'd16);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);

    // Fill the stack, then one more ecall overflows.
    cyc("ecall_fill", 1, 0, 32'hA0, 1, 0, 0, 4'h0);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("idle", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    cyc("ecall_over", 1, 0, 32'hB0, 1, 0, 0, 4'h0);
    check("over_depth", 32'(bus.depth), 32'd2);

    // Masked irq line with mask write, then reset in REDIR.
    rst = 1'b1;
    cyc("reset2", 0, 0, 32'd0, 0, 0, 0, 4'h0);
    rst = 1'b0;
    cyc("mask_wr", 0, 0, 32'd0, 0, 0, 0, 4'b0001, 1'b1, 4'b1110);
    cyc("irq_masked", 1, 0, 32'hC0, 0, 0, 0, 4'b0001);
    check("masked_noflush", 32'(bus.flush), 32'd0);
    cyc("ecall_r", 1, 0, 32'hD0, 1, 0, 0, 4'h0);
    rst = 1'b1;
    cyc("rst_in_redir", 1, 0, 32'hE0, 1, 0, 0, 4'h0);
    rst = 1'b0;

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cyc("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
          {$urandom_range(0, 32'h3FFF), 2'b00},
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
          ($urandom_range(0, 15) == 0), 4'($urandom));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
